// File: rtl/smol_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smol_pkg
// Description : Shared types and constants for the smolCore fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package smol_pkg;

   localparam int          SMOL_XLEN = 32;
   localparam logic [31:0] SMOL_NOP  = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [SMOL_XLEN-1:0] pc;
      logic [SMOL_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/smol_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : smol_fetch_ctrl_if
// Description : Instruction-memory handshake, redirect and decode-side
//               valid/ready signals of the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface smol_fetch_ctrl_if;
   import smol_pkg::*;

   // instruction memory
   logic                 imem_req;
   logic [SMOL_XLEN-1:0] imem_addr;
   logic                 imem_gnt;
   logic                 imem_rvalid;
   logic [SMOL_XLEN-1:0] imem_rdata;
   // execute redirect
   logic                 redirect_valid;
   logic [SMOL_XLEN-1:0] redirect_pc;
   // decoder
   logic                 instr_valid;
   logic [SMOL_XLEN-1:0] instr;
   logic [SMOL_XLEN-1:0] instr_pc;
   logic                 instr_ready;

   // Fetch controller side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
             instr_ready
   );

   // Environment side (memory, execute, decoder)
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
             instr_ready
   );

endinterface
`default_nettype wire

// File: rtl/smol_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : smol_fetch_fifo
// Description : Small synchronous FIFO holding fetched {pc, instr} entries.
//               Flush empties it and overrides any push/pop in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module smol_fetch_fifo
   import smol_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  wire logic                         clk,
   input  wire logic                         rst,
   input  wire logic                         push,
   input  wire logic                         pop,
   input  wire logic                         flush,
   input  wire fetch_entry_t                 wdata,
   output fetch_entry_t                      rdata,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic                              full,
   output logic                              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Next-state of storage, pointers and occupancy; pointers wrap naturally
   // because DEPTH is a power of two.
   always_comb begin
      do_push  = push & ~flush;
      do_pop   = pop & ~flush & (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Registered storage and pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/smol_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : smol_fetch_ctrl
// Description : Instruction fetch sequencer. Owns the fetch PC, issues one
//               outstanding word request at a time, buffers responses with
//               their PC and hands them to decode; redirects squash both
//               in-flight and buffered fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module smol_fetch_ctrl
   import smol_pkg::*;
#(
   parameter logic [SMOL_XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int                   DEPTH    = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   smol_fetch_ctrl_if.master  bus
);

   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_state_t         state_q, state_d;
   logic [SMOL_XLEN-1:0] fetch_pc_q, fetch_pc_d;

   logic                 fifo_push, fifo_pop, fifo_flush;
   logic                 fifo_full, fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   fetch_entry_t         fifo_wdata, fifo_head;

   logic                 req;
   logic                 gnt_taken;

   // Request qualification and buffer control; a grant only counts while
   // the request is actually presented.
   always_comb begin
      req              = !rst && (state_q == FETCH) && (fifo_count < CNT_W'(DEPTH));
      gnt_taken        = req && bus.imem_gnt;
      fifo_flush       = bus.redirect_valid;
      fifo_push        = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
      fifo_pop         = !fifo_empty && bus.instr_ready;
      fifo_wdata.pc    = fetch_pc_q - 32'd4;   // fetch_pc already advanced at grant
      fifo_wdata.instr = bus.imem_rdata;
   end

   // Next state and fetch PC; redirect overrides the PC in every state
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         FETCH: begin
            if (gnt_taken) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = bus.redirect_valid ? DISCARD : WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               state_d = FETCH;
            end else if (bus.redirect_valid) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            // The squashed response closes the outstanding request even if
            // another redirect arrives in the same cycle.
            if (bus.imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      if (bus.redirect_valid) begin
         fetch_pc_d = {bus.redirect_pc[SMOL_XLEN-1:2], 2'b00};
      end
   end

   // FSM state and fetch PC registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // A push into a full buffer would mean a second outstanding request
   always @(posedge clk) begin
      if (!rst && !fifo_flush) begin
         assert (!(fifo_push && fifo_full));
      end
   end

   smol_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .wdata (fifo_wdata),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.imem_req    = req;
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.instr_valid = !fifo_empty;
   assign bus.instr       = fifo_empty ? SMOL_NOP : fifo_head.instr;
   assign bus.instr_pc    = fifo_empty ? '0 : fifo_head.pc;

endmodule
`default_nettype wire
